// File: rtl/pipe_stage_buf.sv
// Elastic inter-stage buffer: main register plus one skid slot, valid/ready on both sides.
// in_ready, out_valid and occupancy all come straight from flops; flush inserts a NOP bubble.
module pipe_stage_buf #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 6,
    parameter logic [31:0] NOP_WORD = 32'hE1A00000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [1:0]                occupancy
);

    localparam int unsigned DW = CHANNELS * WIDTH;
    localparam logic [WIDTH-1:0] NOP_W    = WIDTH'(NOP_WORD);
    localparam logic [DW-1:0]    MAIN_RST = DW'(NOP_W);

    // bit0 = main held, bit1 = skid held; 2'b10 is unreachable
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b11
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DW-1:0]   r_main;
    logic [DW-1:0]   r_skid;
    logic [DW-1:0]   w_main_nxt;
    logic [DW-1:0]   w_skid_nxt;
    logic            r_main_valid;
    logic            r_in_ready;
    logic [1:0]      r_occupancy;
    logic            w_main_valid_nxt;
    logic            w_in_ready_nxt;
    logic [1:0]      w_occupancy_nxt;
    logic            w_ix;
    logic            w_ox;

    assign w_ix = in_valid & r_in_ready;
    assign w_ox = r_main_valid & out_ready;

    assign in_ready  = r_in_ready;
    assign out_valid = r_main_valid;
    assign out_data  = r_main;
    assign occupancy = r_occupancy;

    // State register plus the flag flops that are pre-decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_EMPTY;
            r_main_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_occupancy  <= 2'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_main_valid <= w_main_valid_nxt;
            r_in_ready   <= w_in_ready_nxt;
            r_occupancy  <= w_occupancy_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= MAIN_RST;
            r_skid <= '0;
        end else begin
            r_main <= w_main_nxt;
            r_skid <= w_skid_nxt;
        end
    end

    // Next state and register loads; flush overrides any transfer in the same cycle
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = MAIN_RST;
            w_skid_nxt  = '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_ix) begin
                        w_state_nxt = ST_FULL;
                        w_main_nxt  = in_data;
                    end
                end
                ST_FULL: begin
                    if (w_ix && w_ox) begin
                        w_main_nxt  = in_data;
                    end else if (w_ix) begin
                        w_state_nxt = ST_SKID;
                        w_skid_nxt  = in_data;
                    end else if (w_ox) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (w_ox) begin
                        w_state_nxt = ST_FULL;
                        w_main_nxt  = r_skid;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    always_comb begin
        w_main_valid_nxt = 1'b0;
        w_in_ready_nxt   = 1'b1;
        w_occupancy_nxt  = 2'd0;
        case (w_state_nxt)
            ST_FULL: begin
                w_main_valid_nxt = 1'b1;
                w_occupancy_nxt  = 2'd1;
            end
            ST_SKID: begin
                w_main_valid_nxt = 1'b1;
                w_in_ready_nxt   = 1'b0;
                w_occupancy_nxt  = 2'd2;
            end
            default: begin
                w_main_valid_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: queue-based reference model checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_pipe_stage_buf;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned CHANNELS = 6;
    localparam int unsigned DW       = WIDTH * CHANNELS;
    localparam logic [DW-1:0] NOP_DW = {160'd0, 32'hE1A00000};

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;

    int n_tot;
    int n_bad;
    int n_dut_skid;
    bit chk_en;

    pipe_stage_buf #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .NOP_WORD (32'hE1A00000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [31:0] c0);
        logic [DW-1:0] d;
        d = '0;
        for (int k = 0; k < int'(CHANNELS); k++)
            d[k*WIDTH +: WIDTH] = c0 ^ {8'(k), 24'h0};
        return d;
    endfunction

    // Reference model: the buffer is a FIFO of at most two entries; out_data shows the head,
    // or the last shown word when empty (NOP after reset/flush).
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_shown;

    always @(posedge clk or negedge rst_n) begin
        bit ix;
        bit ox;
        if (!rst_n) begin
            mq.delete();
            m_shown = NOP_DW;
        end else begin
            ix = in_valid && (mq.size() < 2);
            ox = (mq.size() > 0) && out_ready;
            if (flush) begin
                mq.delete();
                m_shown = NOP_DW;
            end else begin
                if (ox) void'(mq.pop_front());
                if (ix) mq.push_back(in_data);
                if (mq.size() > 0) m_shown = mq[0];
            end
        end
    end

    // Single compare process, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_out_valid", DW'(out_valid), DW'(mq.size() > 0));
            chk("cmp_in_ready",  DW'(in_ready),  DW'(mq.size() < 2));
            chk("cmp_occupancy", DW'(occupancy), DW'(mq.size()));
            chk("cmp_out_data",  out_data, m_shown);
            if (occupancy == 2'd2) n_dut_skid++;
        end
    end

    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string nm, input logic v, input logic rdy, input logic [1:0] occ,
                             input logic [31:0] ch0);
        chk({nm, "_valid"}, DW'(out_valid), DW'(v));
        chk({nm, "_ready"}, DW'(in_ready),  DW'(rdy));
        chk({nm, "_occ"},   DW'(occupancy), DW'(occ));
        chk({nm, "_ch0"},   DW'(out_data[31:0]), DW'(ch0));
    endtask

    initial begin
        logic [DW-1:0] rd;
        n_tot = 0; n_bad = 0; n_dut_skid = 0; chk_en = 0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 1'b0, 1'b1, 2'd0, 32'hE1A00000);
        chk("reset_full_data", out_data, NOP_DW);
        rst_n  = 1'b1;
        chk_en = 1;

        // Streaming with out_ready held high: one cycle latency, skid never used
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, mk(32'(i)), 1'b1, 1'b0);
            chk_state("stream", 1'b1, 1'b1, 2'd1, 32'(i));
        end
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk_state("stream_end", 1'b0, 1'b1, 2'd0, 32'h00000010);

        // Backpressure fills main then skid
        cyc(1'b1, mk(32'hAAAA0000), 1'b0, 1'b0);
        chk_state("bp_a", 1'b1, 1'b1, 2'd1, 32'hAAAA0000);
        cyc(1'b1, mk(32'hBBBB0000), 1'b0, 1'b0);
        chk_state("bp_b", 1'b1, 1'b0, 2'd2, 32'hAAAA0000);
        cyc(1'b1, mk(32'hCCCC0000), 1'b0, 1'b0);
        chk_state("bp_hold", 1'b1, 1'b0, 2'd2, 32'hAAAA0000);
        chk("bp_hold_full", out_data, mk(32'hAAAA0000));
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk_state("bp_drain1", 1'b1, 1'b1, 2'd1, 32'hBBBB0000);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk_state("bp_drain2", 1'b0, 1'b1, 2'd0, 32'hBBBB0000);

        // Simultaneous input and output transfer while FULL
        cyc(1'b1, mk(32'h0BADF00D), 1'b0, 1'b0);
        cyc(1'b1, mk(32'h12345678), 1'b1, 1'b0);
        chk_state("ixox", 1'b1, 1'b1, 2'd1, 32'h12345678);
        cyc(1'b0, '0, 1'b1, 1'b0);

        // Flush while in SKID with a live input transfer offered
        cyc(1'b1, mk(32'h11110000), 1'b0, 1'b0);
        cyc(1'b1, mk(32'h22220000), 1'b0, 1'b0);
        chk_state("pre_flush", 1'b1, 1'b0, 2'd2, 32'h11110000);
        cyc(1'b1, mk(32'hDEADBEEF), 1'b0, 1'b1);
        chk_state("flush", 1'b0, 1'b1, 2'd0, 32'hE1A00000);
        chk("flush_full_data", out_data, NOP_DW);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, '0, 1'b1, 1'b0);
            chk_state("post_flush", 1'b0, 1'b1, 2'd0, 32'hE1A00000);
        end

        // Asynchronous reset mid-stream at occupancy 2 with in_valid high
        cyc(1'b1, mk(32'h33330000), 1'b0, 1'b0);
        cyc(1'b1, mk(32'h44440000), 1'b0, 1'b0);
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("async_rst", 1'b0, 1'b1, 2'd0, 32'hE1A00000);
        chk("async_rst_full", out_data, NOP_DW);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b1, mk(32'h00000055), 1'b1, 1'b0);
        chk_state("after_rst", 1'b1, 1'b1, 2'd1, 32'h00000055);

        // Randomized valid/ready/flush against the model
        n_dut_skid = 0;
        for (int c = 0; c < 10000; c++) begin
            logic v;
            logic r;
            logic f;
            int rbias;
            rbias = ((c / 500) % 2 == 0) ? 1 : 3;
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) >= rbias);
            f = ($urandom_range(0, 127) == 0);
            for (int k = 0; k < int'(CHANNELS); k++)
                rd[k*WIDTH +: WIDTH] = $urandom;
            cyc(v, rd, r, f);
        end
        chk("random_hit_skid", DW'(n_dut_skid > 0), DW'(1'b1));

        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        chk_state("final_empty", 1'b0, 1'b1, 2'd0, out_data[31:0]);
        chk_en = 0;

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
